// File: rtl/keys_pio_debounced_if.sv
// Avalon-MM slave bus for the debounced key PIO: word address, write strobe,
// registered read data and the level interrupt toward the IRQ mapper.
interface keys_pio_debounced_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/keys_pio_debounced.sv
// Debounced key/switch PIO: per-channel synchroniser, hold-time debouncer, edge select,
// sticky edge capture with IRQ mask and a saturating event counter; reads have 1 clk latency.
module keys_pio_debounced #(
  parameter int              WIDTH           = 4,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_LEVEL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  keys_pio_debounced_if.slave avs
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_w;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  db_q, db_d, db_prev_q;
  logic [WIDTH-1:0]                  mask_q, mask_d;
  logic [WIDTH-1:0]                  cap_q, cap_d;
  logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
  logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
  logic [15:0]                       evt_cnt_q, evt_cnt_d;
  logic [31:0]                       rd_q, rd_d;
  logic [WIDTH-1:0]                  evt;
  logic                              any_evt;
  logic                              wr_en;
  logic                              unused_wdata;

  assign sync_w       = sync_q[SYNC_STAGES-1];
  assign wr_en        = avs.chipselect & ~avs.write_n;
  assign unused_wdata = ^avs.writedata;

  // Edges come from the registered debounced level, so reset release cannot fake one.
  assign evt     = (db_q & ~db_prev_q & rise_en_q) | (~db_q & db_prev_q & fall_en_q);
  assign any_evt = |evt;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_w[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i] = sync_w[i];
        else                      cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    cap_d     = cap_q;
    evt_cnt_d = evt_cnt_q;
    if (wr_en) begin
      case (avs.address)
        3'd2:    mask_d    = avs.writedata[WIDTH-1:0];
        3'd3:    cap_d     = cap_q & ~avs.writedata[WIDTH-1:0];
        3'd4:    rise_en_d = avs.writedata[WIDTH-1:0];
        3'd5:    fall_en_d = avs.writedata[WIDTH-1:0];
        default: ;
      endcase
    end
    // A set arriving with a clear wins so no event is dropped.
    cap_d = cap_d | evt;
    if (wr_en && avs.address == 3'd6)         evt_cnt_d = {15'd0, any_evt};
    else if (any_evt && evt_cnt_q != 16'hFFFF) evt_cnt_d = evt_cnt_q + 16'd1;
  end

  always_comb begin
    rd_d = '0;
    case (avs.address)
      3'd0:    rd_d[WIDTH-1:0] = db_q;
      3'd1:    rd_d[WIDTH-1:0] = sync_w;
      3'd2:    rd_d[WIDTH-1:0] = mask_q;
      3'd3:    rd_d[WIDTH-1:0] = cap_q;
      3'd4:    rd_d[WIDTH-1:0] = rise_en_q;
      3'd5:    rd_d[WIDTH-1:0] = fall_en_q;
      3'd6:    rd_d[15:0]      = evt_cnt_q;
      default: rd_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q     <= '0;
      db_q      <= RESET_LEVEL;
      db_prev_q <= RESET_LEVEL;
      mask_q    <= '0;
      cap_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '1;
      evt_cnt_q <= '0;
      rd_q      <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
      cnt_q     <= cnt_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      evt_cnt_q <= evt_cnt_d;
      rd_q      <= rd_d;
    end
  end

  assign avs.readdata = rd_q;
  assign avs.irq      = |(cap_q & mask_q);

endmodule
